// File: rtl/regfile_sb_if.sv
// Bus between the decode stage and the scoreboarded register file: write port,
// two read ports, reserve port, and the ready flag of the post-reset clear.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_reg_write;
  logic [ADDR_W-1:0] i_write_register;
  logic [DATA_W-1:0] i_write_data;
  logic [ADDR_W-1:0] i_read_register1;
  logic [ADDR_W-1:0] i_read_register2;
  logic              i_rsv_en;
  logic [ADDR_W-1:0] i_rsv_reg;
  logic [DATA_W-1:0] o_read_data1;
  logic [DATA_W-1:0] o_read_data2;
  logic              o_busy1;
  logic              o_busy2;
  logic              o_ready;

  modport master (
    output i_reg_write, i_write_register, i_write_data,
    output i_read_register1, i_read_register2, i_rsv_en, i_rsv_reg,
    input  o_read_data1, o_read_data2, o_busy1, o_busy2, o_ready
  );

  modport slave (
    input  i_reg_write, i_write_register, i_write_data,
    input  i_read_register1, i_read_register2, i_rsv_en, i_rsv_reg,
    output o_read_data1, o_read_data2, o_busy1, o_busy2, o_ready
  );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with optional write bypass, a sequenced
// post-reset clear (stack pointer preloaded) and per-register busy bits.
module regfile_sb #(
  parameter int                   DATA_W  = 32,
  parameter int                   ADDR_W  = 5,
  parameter int unsigned          SP_IDX  = 29,
  parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'('h600),
  parameter int                   BYPASS  = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_PTR = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST   = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DEPTH-1:0]  busy;
  logic              ready;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic              rsv_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rsv_idx;

  assign wr_en   = bus.i_reg_write && (bus.i_write_register != '0);
  assign rsv_en  = bus.i_rsv_en && (bus.i_rsv_reg != '0);
  assign wr_idx  = bus.i_write_register;
  assign rsv_idx = bus.i_rsv_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      ptr   <= ADDR_W'(1);
      busy  <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // NOTE: two non-blocking writes to the same bit; the later one (set) wins,
          // so a new producer reserved on the retire edge keeps the register busy.
          if (wr_en)  busy[wr_idx]  <= 1'b0;
          if (rsv_en) busy[rsv_idx] <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: the array has no reset branch so it maps onto plain RAM/flops without
  // a reset net; the INIT sweep is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        mem[ptr] <= (ptr == SP_PTR) ? SP_INIT : '0;
      else if (wr_en)
        mem[wr_idx] <= bus.i_write_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    if (state != RUN || idx == '0)         return '0;
    if (BYPASS != 0 && wr_en && wr_idx == idx) return bus.i_write_data;
    return mem[idx];
  endfunction

  // A retiring write hides the busy bit only when bypass can supply the data
  // and no same-cycle reserve re-marks the register.
  function automatic logic busy_port(input logic [ADDR_W-1:0] idx);
    if (state != RUN) return 1'b0;
    if (BYPASS != 0 && wr_en && wr_idx == idx && !(rsv_en && rsv_idx == idx)) return 1'b0;
    return busy[idx];
  endfunction

  always_comb begin
    bus.o_read_data1 = read_port(bus.i_read_register1);
    bus.o_read_data2 = read_port(bus.i_read_register2);
    bus.o_busy1      = busy_port(bus.i_read_register1);
    bus.o_busy2      = busy_port(bus.i_read_register2);
    bus.o_ready      = ready;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: stimulus pushes expected outputs of a bypassing and a
// non-bypassing instance; a negedge monitor pops and compares them.
module tb_regfile_sb;
  logic clk;
  logic reset;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  regfile_sb #(.BYPASS(1)) u_dut_byp  (.clk(clk), .reset(reset), .bus(bus1));
  regfile_sb #(.BYPASS(0)) u_dut_nbyp (.clk(clk), .reset(reset), .bus(bus0));

  assign bus0.i_reg_write      = bus1.i_reg_write;
  assign bus0.i_write_register = bus1.i_write_register;
  assign bus0.i_write_data     = bus1.i_write_data;
  assign bus0.i_read_register1 = bus1.i_read_register1;
  assign bus0.i_read_register2 = bus1.i_read_register2;
  assign bus0.i_rsv_en         = bus1.i_rsv_en;
  assign bus0.i_rsv_reg        = bus1.i_rsv_reg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
    else             n_passed++;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 1) begin
        check({e.name, "/byp/d1"},  bus1.o_read_data1, e.d1);
        check({e.name, "/byp/d2"},  bus1.o_read_data2, e.d2);
        check({e.name, "/byp/b1"},  32'(bus1.o_busy1), 32'(e.b1));
        check({e.name, "/byp/b2"},  32'(bus1.o_busy2), 32'(e.b2));
        check({e.name, "/byp/rdy"}, 32'(bus1.o_ready), 32'(e.rdy));
      end else begin
        check({e.name, "/nbyp/d1"},  bus0.o_read_data1, e.d1);
        check({e.name, "/nbyp/d2"},  bus0.o_read_data2, e.d2);
        check({e.name, "/nbyp/b1"},  32'(bus0.o_busy1), 32'(e.b1));
        check({e.name, "/nbyp/b2"},  32'(bus0.o_busy2), 32'(e.b2));
        check({e.name, "/nbyp/rdy"}, 32'(bus0.o_ready), 32'(e.rdy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic rsv, input logic [4:0] rr);
    bus1.i_reg_write      = we;
    bus1.i_write_register = wa;
    bus1.i_write_data     = wd;
    bus1.i_read_register1 = r1;
    bus1.i_read_register2 = r2;
    bus1.i_rsv_en         = rsv;
    bus1.i_rsv_reg        = rr;
  endtask

  task automatic expect_out(input string name, input int dut, input logic [31:0] d1,
                            input logic [31:0] d2, input logic b1, input logic b2,
                            input logic rdy);
    exp_t x;
    x.name = name; x.dut = dut; x.d1 = d1; x.d2 = d2; x.b1 = b1; x.b2 = b2; x.rdy = rdy;
    sb.push_back(x);
  endtask

  task automatic expect_both(input string name, input logic [31:0] d1, input logic [31:0] d2,
                             input logic b1, input logic b2, input logic rdy);
    expect_out(name, 1, d1, d2, b1, b2, rdy);
    expect_out(name, 0, d1, d2, b1, b2, rdy);
  endtask

  // Reference state for the random phase.
  logic [31:0] m_mem [32];
  logic        m_busy [32];

  function automatic logic [4:0] pick();
    int r = $urandom_range(0, 9);
    if (r == 8) return 5'd29;
    if (r == 9) return 5'd31;
    return 5'(r);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input int byp, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (byp == 1 && we && wa == idx) return wd;
    return m_mem[idx];
  endfunction

  function automatic logic m_busy_out(input logic [4:0] idx, input int byp, input logic we,
                                      input logic [4:0] wa, input logic rsv, input logic [4:0] rr);
    if (idx == 5'd0) return 1'b0;
    if (byp == 1 && we && wa == idx && !(rsv && rr == idx)) return 1'b0;
    return m_busy[idx];
  endfunction

  initial begin
    logic        we, rsv;
    logic [4:0]  wa, r1, r2, rr;
    logic [31:0] wd;

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_both("reset_held", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Clear sequence interrupted on its 10th edge; writes/reserves of r2 are ignored.
    for (int k = 1; k <= 9; k++) begin
      set_in(1, 2, 32'hAAAA_5555, 2, 29, 1, 2);
      expect_both("init_a", 0, 0, 0, 0, 0);
      tick();
    end
    reset = 1'b1;
    expect_both("init_a_reset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      set_in(1, 2, 32'hAAAA_5555, 2, 29, 1, 2);
      expect_both("init_b", 0, 0, 0, 0, 0);
      tick();
    end

    set_in(0, 0, 0, 29, 5, 0, 0);
    expect_both("sp_init", 32'h600, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 2, 31, 0, 0);
    expect_both("r2_lost", 0, 0, 0, 0, 1);
    tick();

    set_in(1, 3, 32'hDEADBEEF, 3, 4, 0, 0);
    expect_out("bypass_wr", 1, 32'hDEADBEEF, 0, 0, 0, 1);
    expect_out("bypass_wr", 0, 0,            0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 3, 3, 0, 0);
    expect_both("after_wr", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1);
    tick();

    set_in(1, 0, 32'h1234, 0, 0, 0, 0);
    expect_both("r0_wr", 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_both("r0_after", 0, 0, 0, 0, 1);
    tick();

    set_in(0, 0, 0, 7, 7, 1, 7);
    expect_both("rsv7_cycle", 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 7, 3, 0, 0);
    expect_both("rsv7_after", 0, 32'hDEADBEEF, 1, 0, 1);
    tick();
    set_in(1, 7, 32'h77, 7, 7, 0, 0);
    expect_out("retire7", 1, 32'h77, 32'h77, 0, 0, 1);
    expect_out("retire7", 0, 0,      0,      1, 1, 1);
    tick();
    set_in(0, 0, 0, 7, 7, 0, 0);
    expect_both("retire7_after", 32'h77, 32'h77, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 7, 7, 1, 7);
    expect_both("rsv7_again", 32'h77, 32'h77, 0, 0, 1);
    tick();
    set_in(1, 7, 32'h88, 7, 7, 1, 7);
    expect_out("rsv_and_wr", 1, 32'h88, 32'h88, 1, 1, 1);
    expect_out("rsv_and_wr", 0, 32'h77, 32'h77, 1, 1, 1);
    tick();
    set_in(0, 0, 0, 7, 7, 1, 7);
    expect_both("set_wins", 32'h88, 32'h88, 1, 1, 1);
    tick();
    set_in(0, 0, 0, 7, 7, 1, 0);
    expect_both("rsv_busy_twice", 32'h88, 32'h88, 1, 1, 1);
    tick();
    set_in(0, 0, 0, 0, 7, 0, 0);
    expect_both("rsv_r0", 0, 32'h88, 0, 1, 1);
    tick();
    set_in(1, 7, 32'h99, 7, 0, 0, 0);
    expect_out("retire7_b", 1, 32'h99, 0, 0, 0, 1);
    expect_out("retire7_b", 0, 32'h88, 0, 1, 0, 1);
    tick();

    // Reset from RUN restarts the full clear sequence.
    reset = 1'b1;
    set_in(1, 2, 32'h5, 0, 0, 0, 0);
    expect_both("run_reset", 0, 0, 0, 0, 1);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      set_in(1, 2, 32'h5, 29, 7, 1, 7);
      expect_both("reinit", 0, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 29, 7, 0, 0);
    expect_both("reinit_done", 32'h600, 0, 0, 0, 1);
    tick();

    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_mem[29] = 32'h600;

    for (int c = 0; c < 1500; c++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = pick();
      wd  = $urandom;
      r1  = pick();
      r2  = pick();
      rsv = 1'($urandom_range(0, 1));
      rr  = pick();
      set_in(we, wa, wd, r1, r2, rsv, rr);
      for (int d = 0; d < 2; d++)
        expect_out("random", d,
                   m_read(r1, d, we, wa, wd), m_read(r2, d, we, wa, wd),
                   m_busy_out(r1, d, we, wa, rsv, rr), m_busy_out(r2, d, we, wa, rsv, rr), 1);
      tick();
      if (we && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rsv && rr != 5'd0) m_busy[rr] = 1'b1;
    end

    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end
endmodule
